mul_issue_queue: RTL and testbench

Issue queue for the multiply pipe: holds dispatched multiply ops, captures operand values from writeback broadcasts, and drives the single-issue request interface (valid_mul, Pw_mul, tag_ROB_mul, busA_mul, busB_mul) consumed by the two-stage multiplier unit. It sits between rename/dispatch and the multiplier in the back end. It obeys the same flush and freeze_back controls as the multiplier, so no op is lost or duplicated across the handoff.

---
 rtl/mul_iq_pkg.sv | 23 ++
 rtl/mul_iq_wakeup.sv | 34 +++
 rtl/mul_issue_queue.sv | 228 ++++++++++++++++++++++
 tb/tb_mul_issue_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_iq_pkg.sv
// Shared types and widths for the multiply issue queue.
// Contents:
//   PREG_W, ROB_W, DATA_W  physical register tag, ROB tag and operand widths
//   mul_iq_entry_t         one queue slot: valid, Pw, tag_ROB, Pa, Pb, rdyA, rdyB, dataA, dataB
package mul_iq_pkg;

  localparam int unsigned PREG_W = 5;
  localparam int unsigned ROB_W  = 5;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] Pw;
    logic [ROB_W-1:0]  tag_ROB;
    logic [PREG_W-1:0] Pa;
    logic [PREG_W-1:0] Pb;
    logic              rdyA;
    logic              rdyB;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;
  } mul_iq_entry_t;

endpackage

// File: rtl/mul_iq_wakeup.sv
// Combinational tag match of one source tag against the writeback broadcast bus.
// Ports:
//   tag      source physical register to look for
//   wb_valid per-port broadcast valid
//   wb_Pw    broadcast tags, port i at [5i+4:5i]
//   wb_data  broadcast values, port i at [16i+15:16i]
//   hit      some valid port carries tag
//   data     value from the lowest-index matching port (0 when no hit)
module mul_iq_wakeup
  import mul_iq_pkg::*;
#(
  parameter int unsigned WB_PORTS = 3
) (
  input  logic [PREG_W-1:0]          tag,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0] wb_Pw,
  input  logic [WB_PORTS*DATA_W-1:0] wb_data,
  output logic                       hit,
  output logic [DATA_W-1:0]          data
);

  // Scan from the highest port down so the lowest matching port is written last.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = int'(WB_PORTS) - 1; i >= 0; i--) begin
      if (wb_valid[i] && (wb_Pw[i*PREG_W +: PREG_W] == tag)) begin
        hit  = 1'b1;
        data = wb_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mul_issue_queue.sv
// Compacting issue queue in front of the two-stage multiplier. Holds dispatched ops, snoops
// writeback broadcasts for operand wakeup and presents the oldest ready op on a registered
// single-issue interface.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   flush                    squash all entries and clear issue registers
//   freeze_back              hold issue registers and queue order (dispatch/wakeup continue)
//   valid_dispatch .. dataB_dispatch  dispatch request and operand state
//   wb_valid, wb_Pw, wb_data writeback broadcast ports
//   full                     count == DEPTH
//   valid_mul, Pw_mul, tag_ROB_mul, busA_mul, busB_mul  registered issue outputs
module mul_issue_queue
  import mul_iq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WB_PORTS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       freeze_back,
  input  logic                       valid_dispatch,
  input  logic [PREG_W-1:0]          Pw_dispatch,
  input  logic [ROB_W-1:0]           tag_ROB_dispatch,
  input  logic [PREG_W-1:0]          Pa_dispatch,
  input  logic [PREG_W-1:0]          Pb_dispatch,
  input  logic                       readyA_dispatch,
  input  logic                       readyB_dispatch,
  input  logic [DATA_W-1:0]          dataA_dispatch,
  input  logic [DATA_W-1:0]          dataB_dispatch,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0] wb_Pw,
  input  logic [WB_PORTS*DATA_W-1:0] wb_data,
  output logic                       full,
  output logic                       valid_mul,
  output logic [PREG_W-1:0]          Pw_mul,
  output logic [ROB_W-1:0]           tag_ROB_mul,
  output logic [DATA_W-1:0]          busA_mul,
  output logic [DATA_W-1:0]          busB_mul
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  mul_iq_entry_t     q_q   [DEPTH];
  mul_iq_entry_t     q_d   [DEPTH];
  mul_iq_entry_t     woken [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d, count_mid;

  logic [DEPTH-1:0]  hit_a, hit_b;
  logic [DATA_W-1:0] wk_a [DEPTH];
  logic [DATA_W-1:0] wk_b [DEPTH];
  logic              hit_da, hit_db;
  logic [DATA_W-1:0] wk_da, wk_db;

  mul_iq_entry_t     sel_entry, disp_entry;
  logic              sel_found;
  logic [DEPTH-1:0]  shift;
  logic              issue, disp_ok;

  logic              valid_mul_q, valid_mul_d;
  logic [PREG_W-1:0] Pw_mul_q, Pw_mul_d;
  logic [ROB_W-1:0]  tag_ROB_mul_q, tag_ROB_mul_d;
  logic [DATA_W-1:0] busA_mul_q, busA_mul_d, busB_mul_q, busB_mul_d;

  // Wakeup comparators: two per entry plus two for the dispatch bypass.
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_wk
    mul_iq_wakeup #(.WB_PORTS(WB_PORTS)) u_wk_a (
      .tag      (q_q[g].Pa),
      .wb_valid (wb_valid),
      .wb_Pw    (wb_Pw),
      .wb_data  (wb_data),
      .hit      (hit_a[g]),
      .data     (wk_a[g])
    );
    mul_iq_wakeup #(.WB_PORTS(WB_PORTS)) u_wk_b (
      .tag      (q_q[g].Pb),
      .wb_valid (wb_valid),
      .wb_Pw    (wb_Pw),
      .wb_data  (wb_data),
      .hit      (hit_b[g]),
      .data     (wk_b[g])
    );
  end

  mul_iq_wakeup #(.WB_PORTS(WB_PORTS)) u_wk_da (
    .tag      (Pa_dispatch),
    .wb_valid (wb_valid),
    .wb_Pw    (wb_Pw),
    .wb_data  (wb_data),
    .hit      (hit_da),
    .data     (wk_da)
  );

  mul_iq_wakeup #(.WB_PORTS(WB_PORTS)) u_wk_db (
    .tag      (Pb_dispatch),
    .wb_valid (wb_valid),
    .wb_Pw    (wb_Pw),
    .wb_data  (wb_data),
    .hit      (hit_db),
    .data     (wk_db)
  );

  assign full    = (count_q == CNT_W'(DEPTH));
  assign disp_ok = valid_dispatch && !full && !flush;

  // Select on registered ready bits; shift marks the selected slot and every younger one.
  always_comb begin
    sel_found = 1'b0;
    sel_entry = '0;
    shift     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!sel_found && q_q[i].valid && q_q[i].rdyA && q_q[i].rdyB) begin
        sel_found = 1'b1;
        sel_entry = q_q[i];
      end
      shift[i] = sel_found;
    end
  end

  assign issue = sel_found && !freeze_back && !flush;

  always_comb begin
    disp_entry         = '0;
    disp_entry.valid   = 1'b1;
    disp_entry.Pw      = Pw_dispatch;
    disp_entry.tag_ROB = tag_ROB_dispatch;
    disp_entry.Pa      = Pa_dispatch;
    disp_entry.Pb      = Pb_dispatch;
    disp_entry.rdyA    = readyA_dispatch || hit_da;
    disp_entry.rdyB    = readyB_dispatch || hit_db;
    disp_entry.dataA   = readyA_dispatch ? dataA_dispatch : wk_da;
    disp_entry.dataB   = readyB_dispatch ? dataB_dispatch : wk_db;
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      woken[i] = q_q[i];
      if (q_q[i].valid && !q_q[i].rdyA && hit_a[i]) begin
        woken[i].rdyA  = 1'b1;
        woken[i].dataA = wk_a[i];
      end
      if (q_q[i].valid && !q_q[i].rdyB && hit_b[i]) begin
        woken[i].rdyB  = 1'b1;
        woken[i].dataB = wk_b[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      q_d[i] = woken[i];
    end
    if (issue) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (shift[i]) q_d[i] = woken[i+1];
      end
      // Queue is compacted, so after a dequeue the top slot is always empty.
      q_d[DEPTH-1] = '0;
    end
    count_mid = count_q - CNT_W'(issue);
    if (disp_ok) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CNT_W'(i) == count_mid) q_d[i] = disp_entry;
      end
    end
    count_d = count_mid + CNT_W'(disp_ok);
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_d[i] = '0;
      end
      count_d = '0;
    end
  end

  always_comb begin
    valid_mul_d   = valid_mul_q;
    Pw_mul_d      = Pw_mul_q;
    tag_ROB_mul_d = tag_ROB_mul_q;
    busA_mul_d    = busA_mul_q;
    busB_mul_d    = busB_mul_q;
    if (flush) begin
      valid_mul_d   = 1'b0;
      Pw_mul_d      = '0;
      tag_ROB_mul_d = '0;
      busA_mul_d    = '0;
      busB_mul_d    = '0;
    end else if (!freeze_back) begin
      valid_mul_d = sel_found;
      if (sel_found) begin
        Pw_mul_d      = sel_entry.Pw;
        tag_ROB_mul_d = sel_entry.tag_ROB;
        busA_mul_d    = sel_entry.dataA;
        busB_mul_d    = sel_entry.dataB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_q[i] <= '0;
      end
      count_q       <= '0;
      valid_mul_q   <= 1'b0;
      Pw_mul_q      <= '0;
      tag_ROB_mul_q <= '0;
      busA_mul_q    <= '0;
      busB_mul_q    <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_q[i] <= q_d[i];
      end
      count_q       <= count_d;
      valid_mul_q   <= valid_mul_d;
      Pw_mul_q      <= Pw_mul_d;
      tag_ROB_mul_q <= tag_ROB_mul_d;
      busA_mul_q    <= busA_mul_d;
      busB_mul_q    <= busB_mul_d;
    end
  end

  assign valid_mul   = valid_mul_q;
  assign Pw_mul      = Pw_mul_q;
  assign tag_ROB_mul = tag_ROB_mul_q;
  assign busA_mul    = busA_mul_q;
  assign busB_mul    = busB_mul_q;

endmodule

// File: tb/tb_mul_issue_queue.sv
// Self-checking bench for mul_issue_queue: a per-cycle table of inputs and expected registered
// outputs, followed by a hand-written asynchronous-reset sequence.
module tb_mul_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, freeze_back, valid_dispatch;
  logic [4:0]  Pw_dispatch, tag_ROB_dispatch, Pa_dispatch, Pb_dispatch;
  logic        readyA_dispatch, readyB_dispatch;
  logic [15:0] dataA_dispatch, dataB_dispatch;
  logic [2:0]  wb_valid;
  logic [14:0] wb_Pw;
  logic [47:0] wb_data;
  logic        full, valid_mul;
  logic [4:0]  Pw_mul, tag_ROB_mul;
  logic [15:0] busA_mul, busB_mul;

  always #5 clk = ~clk;

  mul_issue_queue #(.DEPTH(4), .WB_PORTS(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .freeze_back      (freeze_back),
    .valid_dispatch   (valid_dispatch),
    .Pw_dispatch      (Pw_dispatch),
    .tag_ROB_dispatch (tag_ROB_dispatch),
    .Pa_dispatch      (Pa_dispatch),
    .Pb_dispatch      (Pb_dispatch),
    .readyA_dispatch  (readyA_dispatch),
    .readyB_dispatch  (readyB_dispatch),
    .dataA_dispatch   (dataA_dispatch),
    .dataB_dispatch   (dataB_dispatch),
    .wb_valid         (wb_valid),
    .wb_Pw            (wb_Pw),
    .wb_data          (wb_data),
    .full             (full),
    .valid_mul        (valid_mul),
    .Pw_mul           (Pw_mul),
    .tag_ROB_mul      (tag_ROB_mul),
    .busA_mul         (busA_mul),
    .busB_mul         (busB_mul)
  );

  // One cycle: inputs applied before an edge, expected outputs just after it.
  typedef struct packed {
    logic        dv;
    logic [4:0]  dpw, drob, dpa, dpb;
    logic        dra, drb;
    logic [15:0] dda, ddb;
    logic [2:0]  wbv;
    logic [14:0] wbpw;
    logic [47:0] wbd;
    logic        fz, fl;
    logic        ev;
    logic [4:0]  epw, erob;
    logic [15:0] ea, eb;
    logic        efull;
    logic        chk_all;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  function automatic vec_t v_nop();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t v_dsp(vec_t vi, logic [4:0] pw, logic [4:0] rob, logic [4:0] pa,
                                 logic [4:0] pb, logic ra, logic rb, logic [15:0] da,
                                 logic [15:0] db);
    vec_t v;
    v = vi;
    v.dv = 1'b1; v.dpw = pw; v.drob = rob; v.dpa = pa; v.dpb = pb;
    v.dra = ra; v.drb = rb; v.dda = da; v.ddb = db;
    return v;
  endfunction

  function automatic vec_t v_wb(vec_t vi, int port, logic [4:0] pw, logic [15:0] d);
    vec_t v;
    v = vi;
    v.wbv[port] = 1'b1;
    v.wbpw[port*5 +: 5] = pw;
    v.wbd[port*16 +: 16] = d;
    return v;
  endfunction

  function automatic vec_t v_exp(vec_t vi, logic [4:0] pw, logic [4:0] rob, logic [15:0] a,
                                 logic [15:0] b);
    vec_t v;
    v = vi;
    v.ev = 1'b1; v.epw = pw; v.erob = rob; v.ea = a; v.eb = b;
    return v;
  endfunction

  function automatic vec_t v_full(vec_t vi);
    vec_t v;
    v = vi;
    v.efull = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_frz(vec_t vi);
    vec_t v;
    v = vi;
    v.fz = 1'b1;
    return v;
  endfunction

  task automatic drive(vec_t v);
    valid_dispatch   = v.dv;
    Pw_dispatch      = v.dpw;
    tag_ROB_dispatch = v.drob;
    Pa_dispatch      = v.dpa;
    Pb_dispatch      = v.dpb;
    readyA_dispatch  = v.dra;
    readyB_dispatch  = v.drb;
    dataA_dispatch   = v.dda;
    dataB_dispatch   = v.ddb;
    wb_valid         = v.wbv;
    wb_Pw            = v.wbpw;
    wb_data          = v.wbd;
    freeze_back      = v.fz;
    flush            = v.fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(int n, vec_t v);
    logic ok;
    checks++;
    ok = (valid_mul === v.ev) && (full === v.efull);
    if (v.ev || v.chk_all) begin
      ok = ok && (Pw_mul === v.epw) && (tag_ROB_mul === v.erob) &&
           (busA_mul === v.ea) && (busB_mul === v.eb);
    end
    if (!ok) begin
      errors++;
      $display("FAIL row %0d: got v=%0b pw=%0d rob=%0d a=%h b=%h full=%0b; want v=%0b pw=%0d rob=%0d a=%h b=%h full=%0b",
               n, valid_mul, Pw_mul, tag_ROB_mul, busA_mul, busB_mul, full,
               v.ev, v.epw, v.erob, v.ea, v.eb, v.efull);
    end
  endtask

  task automatic check_val(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_zero_outputs(string name);
    check_val({name, "_valid"}, 32'(valid_mul), 32'd0);
    check_val({name, "_full"},  32'(full), 32'd0);
    check_val({name, "_pw"},    32'(Pw_mul), 32'd0);
    check_val({name, "_rob"},   32'(tag_ROB_mul), 32'd0);
    check_val({name, "_busA"},  32'(busA_mul), 32'd0);
    check_val({name, "_busB"},  32'(busB_mul), 32'd0);
  endtask

  initial begin
    vec_t v;

    // Basic ready-at-dispatch issue.
    tbl.push_back(v_dsp(v_nop(), 5'd7, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0003, 16'h0005));
    tbl.push_back(v_exp(v_nop(), 5'd7, 5'd2, 16'h0003, 16'h0005));
    tbl.push_back(v_nop());
    // Wakeup via wb port 1 two cycles after dispatch.
    tbl.push_back(v_dsp(v_nop(), 5'd10, 5'd3, 5'd9, 5'd4, 1'b0, 1'b1, 16'h0000, 16'h0002));
    tbl.push_back(v_nop());
    tbl.push_back(v_wb(v_nop(), 1, 5'd9, 16'h0010));
    tbl.push_back(v_exp(v_nop(), 5'd10, 5'd3, 16'h0010, 16'h0002));
    tbl.push_back(v_nop());
    // Two ports match the same tag: lowest port wins.
    tbl.push_back(v_dsp(v_nop(), 5'd11, 5'd4, 5'd9, 5'd5, 1'b0, 1'b1, 16'h0000, 16'h0007));
    tbl.push_back(v_wb(v_wb(v_nop(), 0, 5'd9, 16'hAAAA), 2, 5'd9, 16'hBBBB));
    tbl.push_back(v_exp(v_nop(), 5'd11, 5'd4, 16'hAAAA, 16'h0007));
    tbl.push_back(v_nop());
    // Dispatch bypass: both operands woken in the dispatch cycle.
    tbl.push_back(v_wb(v_wb(v_dsp(v_nop(), 5'd12, 5'd5, 5'd20, 5'd21, 1'b0, 1'b0, 16'h0, 16'h0),
                            2, 5'd20, 16'h1234), 0, 5'd21, 16'h5678));
    tbl.push_back(v_exp(v_nop(), 5'd12, 5'd5, 16'h1234, 16'h5678));
    tbl.push_back(v_nop());
    // Ordering: older not ready, younger ready -> younger first, then older after wakeup.
    tbl.push_back(v_dsp(v_nop(), 5'd13, 5'd6, 5'd22, 5'd1, 1'b0, 1'b1, 16'h0000, 16'h0001));
    tbl.push_back(v_dsp(v_nop(), 5'd14, 5'd7, 5'd1, 5'd1, 1'b1, 1'b1, 16'h000E, 16'h000F));
    tbl.push_back(v_exp(v_wb(v_nop(), 0, 5'd22, 16'h0016), 5'd14, 5'd7, 16'h000E, 16'h000F));
    tbl.push_back(v_exp(v_nop(), 5'd13, 5'd6, 16'h0016, 16'h0001));
    tbl.push_back(v_nop());
    // Two ready ops in dispatch order; second dispatch coincides with an issue.
    tbl.push_back(v_dsp(v_nop(), 5'd15, 5'd8, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0001, 16'h0002));
    tbl.push_back(v_exp(v_dsp(v_nop(), 5'd16, 5'd9, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0003, 16'h0004),
                        5'd15, 5'd8, 16'h0001, 16'h0002));
    tbl.push_back(v_exp(v_nop(), 5'd16, 5'd9, 16'h0003, 16'h0004));
    tbl.push_back(v_nop());
    // Fill with four non-ready ops; fifth (ready) dispatch must be dropped.
    tbl.push_back(v_dsp(v_nop(), 5'd17, 5'd10, 5'd30, 5'd30, 1'b0, 1'b0, 16'h0, 16'h0));
    tbl.push_back(v_dsp(v_nop(), 5'd18, 5'd11, 5'd30, 5'd30, 1'b0, 1'b0, 16'h0, 16'h0));
    tbl.push_back(v_dsp(v_nop(), 5'd19, 5'd12, 5'd30, 5'd30, 1'b0, 1'b0, 16'h0, 16'h0));
    tbl.push_back(v_full(v_dsp(v_nop(), 5'd20, 5'd13, 5'd30, 5'd30, 1'b0, 1'b0, 16'h0, 16'h0)));
    tbl.push_back(v_full(v_dsp(v_nop(), 5'd21, 5'd14, 5'd1, 5'd1, 1'b1, 1'b1, 16'h9, 16'h9)));
    tbl.push_back(v_full(v_nop()));
    // Flush, then a wakeup for the flushed tag must not issue anything.
    v = v_nop(); v.fl = 1'b1;
    tbl.push_back(v);
    tbl.push_back(v_wb(v_nop(), 0, 5'd30, 16'h0001));
    tbl.push_back(v_nop());
    tbl.push_back(v_nop());
    // Freeze: presented op held three cycles while dispatch continues underneath.
    tbl.push_back(v_dsp(v_nop(), 5'd3, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0033, 16'h0044));
    tbl.push_back(v_exp(v_dsp(v_nop(), 5'd5, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0055, 16'h0066),
                        5'd3, 5'd1, 16'h0033, 16'h0044));
    tbl.push_back(v_exp(v_frz(v_nop()), 5'd3, 5'd1, 16'h0033, 16'h0044));
    tbl.push_back(v_exp(v_frz(v_dsp(v_nop(), 5'd6, 5'd3, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0001,
                                    16'h0001)), 5'd3, 5'd1, 16'h0033, 16'h0044));
    tbl.push_back(v_exp(v_frz(v_nop()), 5'd3, 5'd1, 16'h0033, 16'h0044));
    tbl.push_back(v_exp(v_nop(), 5'd5, 5'd2, 16'h0055, 16'h0066));
    tbl.push_back(v_exp(v_nop(), 5'd6, 5'd3, 16'h0001, 16'h0001));
    tbl.push_back(v_nop());
    // Flush overrides freeze and dispatch, and zeroes the presented op.
    tbl.push_back(v_dsp(v_nop(), 5'd8, 5'd4, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0002, 16'h0002));
    tbl.push_back(v_exp(v_dsp(v_nop(), 5'd9, 5'd5, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0007, 16'h0007),
                        5'd8, 5'd4, 16'h0002, 16'h0002));
    v = v_frz(v_dsp(v_nop(), 5'd10, 5'd6, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0003, 16'h0003));
    v.fl = 1'b1; v.chk_all = 1'b1;
    tbl.push_back(v);
    tbl.push_back(v_nop());
    tbl.push_back(v_nop());

    rst = 1'b0;
    drive(v_nop());
    repeat (2) step();
    check_zero_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      step();
      check_row(i, tbl[i]);
    end

    // Asynchronous reset with three entries queued and stale values on the issue bus.
    drive(v_dsp(v_nop(), 5'd1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0005, 16'h0006));
    step();
    drive(v_dsp(v_nop(), 5'd2, 5'd2, 5'd25, 5'd25, 1'b0, 1'b0, 16'h0, 16'h0));
    step();
    check_val("pre_rst_issue_valid", 32'(valid_mul), 32'd1);
    check_val("pre_rst_issue_pw", 32'(Pw_mul), 32'd1);
    drive(v_dsp(v_nop(), 5'd3, 5'd3, 5'd25, 5'd25, 1'b0, 1'b0, 16'h0, 16'h0));
    step();
    drive(v_dsp(v_nop(), 5'd4, 5'd4, 5'd25, 5'd25, 1'b0, 1'b0, 16'h0, 16'h0));
    step();
    drive(v_nop());
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs("midrst");
    step();
    rst = 1'b1;
    drive(v_wb(v_nop(), 0, 5'd25, 16'h0099));
    step();
    check_val("post_rst_idle0", 32'(valid_mul), 32'd0);
    drive(v_nop());
    step();
    check_val("post_rst_idle1", 32'(valid_mul), 32'd0);
    step();
    check_val("post_rst_idle2", 32'(valid_mul), 32'd0);
    check_val("post_rst_full", 32'(full), 32'd0);
    drive(v_dsp(v_nop(), 5'd6, 5'd6, 5'd1, 5'd1, 1'b1, 1'b1, 16'h0007, 16'h0008));
    step();
    drive(v_nop());
    step();
    check_val("post_rst_issue_valid", 32'(valid_mul), 32'd1);
    check_val("post_rst_issue_pw", 32'(Pw_mul), 32'd6);
    check_val("post_rst_issue_busA", 32'(busA_mul), 32'h7);
    check_val("post_rst_issue_busB", 32'(busB_mul), 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
